// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for the two-term shift-add multiplier unit: recodes b into runs of ones,
// issues one (2^i +/- 2^j) term per cycle and accumulates the returned partial products.
module shift_add_mult_ctrl #(
   parameter int a_N = 4,
   parameter int N   = 3,
   localparam int B_W = 1 << N,
   localparam int P_W = a_N + B_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_vld,
   output logic             req_rdy,
   input  logic [a_N-1:0]   req_a,
   input  logic [B_W-1:0]   req_b,
   output logic             rsp_vld,
   input  logic             rsp_rdy,
   output logic [P_W-1:0]   rsp_prod,
   output logic [N-1:0]     rsp_ops,
   output logic [a_N-1:0]   mul_a,
   output logic [N-1:0]     mul_b_i,
   output logic [N-1:0]     mul_b_j,
   output logic             mul_one_term,
   output logic             mul_b_sign,
   output logic             mul_vld,
   input  logic [P_W:0]     mul_c,
   input  logic             mul_c_vld
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t           state, state_nxt;
   logic [a_N-1:0]   a_q;
   logic [B_W-1:0]   b_rem;
   logic [P_W-1:0]   acc;
   logic [N-1:0]     ops;

   logic [N-1:0]     run_j, run_k;
   logic [N:0]       run_len;
   logic [B_W-1:0]   run_mask;

   logic             op_one, op_sign;
   logic [N-1:0]     op_bi, op_bj;
   logic [B_W-1:0]   clr_mask;
   logic [B_W-1:0]   b_rem_nxt;

   // Locate the lowest run of ones in b_rem: start j, end k, length and bit mask.
   always_comb begin
      logic in_run;
      logic run_end;
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      run_j    = '0;
      run_k    = '0;
      run_len  = '0;
      run_mask = '0;
      in_run   = 1'b0;
      run_end  = 1'b0;
      for (int i = 0; i < B_W; i++) begin
         if (b_rem[i] && !run_end) begin
            if (!in_run) run_j = N'(i);
            in_run      = 1'b1;
            run_k       = N'(i);
            run_len     = run_len + (N+1)'(1);
            run_mask[i] = 1'b1;
         end else if (in_run) begin
            run_end = 1'b1;
         end
      end
   end

   // Recode the run into one term op; a long run touching the MSB cannot use 2^(k+1),
   // so it peels off its top two bits as a plain sum instead.
   always_comb begin
      op_one   = 1'b0;
      op_sign  = 1'b0;
      op_bi    = '0;
      op_bj    = '0;
      clr_mask = '0;
      if (run_len == (N+1)'(1)) begin
         op_one   = 1'b1;
         op_bi    = run_j;
         clr_mask = run_mask;
      end else if (run_len == (N+1)'(2)) begin
         op_bi    = run_k;
         op_bj    = run_j;
         clr_mask = run_mask;
      end else if (run_k != N'(B_W-1)) begin
         op_bi    = run_k + N'(1);
         op_bj    = run_j;
         op_sign  = 1'b1;
         clr_mask = run_mask;
      end else begin
         op_bi    = run_k;
         op_bj    = run_k - N'(1);
         clr_mask = {2'b11, {(B_W-2){1'b0}}};
      end
   end

   assign b_rem_nxt = b_rem & ~clr_mask;

   // NOTE: sequential state is updated only with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_vld) state_nxt = (req_b != '0) ? ISSUE : DONE;
         ISSUE:   if (mul_c_vld && (b_rem_nxt == '0)) state_nxt = DONE;
         DONE:    if (rsp_rdy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_rdy      = 1'b0;
      rsp_vld      = 1'b0;
      rsp_prod     = '0;
      rsp_ops      = '0;
      mul_vld      = 1'b0;
      mul_a        = '0;
      mul_b_i      = '0;
      mul_b_j      = '0;
      mul_one_term = 1'b0;
      mul_b_sign   = 1'b0;
      case (state)
         IDLE: req_rdy = 1'b1;
         ISSUE: begin
            mul_vld      = 1'b1;
            mul_a        = a_q;
            mul_b_i      = op_bi;
            mul_b_j      = op_bj;
            mul_one_term = op_one;
            mul_b_sign   = op_sign;
         end
         DONE: begin
            rsp_vld  = 1'b1;
            rsp_prod = acc;
            rsp_ops  = ops;
         end
         default: ;
      endcase
   end

   // Datapath: an op commits only on the cycle the unit returns its partial product.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_rem <= '0;
         acc   <= '0;
         ops   <= '0;
      end else begin
         case (state)
            IDLE: if (req_vld) begin
               a_q   <= req_a;
               b_rem <= req_b;
               acc   <= '0;
               ops   <= '0;
            end
            ISSUE: if (mul_c_vld) begin
               acc   <= acc + mul_c[P_W-1:0];
               b_rem <= b_rem_nxt;
               ops   <= ops + N'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
